// File: rtl/spw_fsm_info_pkg.sv
// Shared definitions for the SpaceWire link FSM-info capture block:
// link state codes, fsm_info bit positions and the legality helper.
package spw_fsm_info_pkg;

  typedef enum logic [2:0] {
    ST_ERROR_RESET = 3'd0,
    ST_ERROR_WAIT  = 3'd1,
    ST_READY       = 3'd2,
    ST_STARTED     = 3'd3,
    ST_CONNECTING  = 3'd4,
    ST_RUN         = 3'd5,
    ST_ILLEGAL_6   = 3'd6,
    ST_ILLEGAL_7   = 3'd7
  } link_state_t;

  localparam int unsigned INFO_W            = 6;
  localparam int unsigned INFO_RUN_SEEN     = 3;
  localparam int unsigned INFO_LINK_DROPPED = 4;
  localparam int unsigned INFO_ERROR_SEEN   = 5;
  localparam int unsigned HIST_DEPTH        = 4;
  localparam int unsigned FILT_CNT_W        = 8;

  function automatic logic is_legal(input link_state_t s);
    return (s <= ST_RUN);
  endfunction

endpackage

// File: rtl/spw_state_filter.sv
// Stability filter: a new link state is committed only after STABLE_CYCLES
// consecutive identical samples; stable illegal codes raise a one-shot pulse.
module spw_state_filter
  import spw_fsm_info_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  link_state_t raw_state,
  output link_state_t filt_state,
  output logic        commit,
  output link_state_t commit_state,
  output logic        illegal_stable
);

  localparam logic [FILT_CNT_W-1:0] STABLE_LIM = FILT_CNT_W'(STABLE_CYCLES);

  link_state_t           cand;
  link_state_t           cand_next;
  logic [FILT_CNT_W-1:0] cnt;
  logic [FILT_CNT_W-1:0] cnt_next;
  logic                  changed;
  logic                  reach;

  // reach fires only on the sample that brings the count to the limit, so a
  // saturated candidate never re-triggers a commit or illegal pulse
  always_comb begin
    changed   = (raw_state != cand);
    cand_next = cand;
    cnt_next  = cnt;
    if (changed) begin
      cand_next = raw_state;
      cnt_next  = FILT_CNT_W'(1);
    end else if (cnt != STABLE_LIM) begin
      cnt_next = cnt + FILT_CNT_W'(1);
    end
    reach          = (cnt_next == STABLE_LIM) && (changed || (cnt != STABLE_LIM));
    commit         = reach && is_legal(cand_next) && (cand_next != filt_state);
    illegal_stable = reach && !is_legal(cand_next);
    commit_state   = cand_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cand       <= ST_ERROR_RESET;
      cnt        <= '0;
      filt_state <= ST_ERROR_RESET;
    end else begin
      cand <= cand_next;
      cnt  <= cnt_next;
      if (commit) begin
        filt_state <= cand_next;
      end
    end
  end

endmodule

// File: rtl/spw_fsm_info_capture.sv
// Packs filtered SpaceWire link state and sticky status into the 6-bit FSM-info
// word. Optional committed-state history enabled by SPW_FSM_INFO_HIST_EN.
module spw_fsm_info_capture
  import spw_fsm_info_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       link_state,
  input  logic             err_event,
  input  logic             clr_sticky,
  output logic [5:0]       fsm_info,
  output logic [CNT_W-1:0] trans_count,
`ifdef SPW_FSM_INFO_HIST_EN
  output logic [11:0]      hist_out,
`endif
  output logic             state_change
);

  link_state_t raw_q;
  logic        err_q;
  link_state_t filt_state;
  link_state_t commit_state;
  logic        commit;
  logic        illegal_stable;
  logic        run_seen;
  logic        link_dropped;
  logic        error_seen;
  logic        set_run;
  logic        set_drop;
  logic        set_err;

  spw_state_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk            (clk),
    .reset_n        (reset_n),
    .raw_state      (raw_q),
    .filt_state     (filt_state),
    .commit         (commit),
    .commit_state   (commit_state),
    .illegal_stable (illegal_stable)
  );

  always_comb begin
    set_run  = commit && (commit_state == ST_RUN);
    set_drop = commit && (filt_state == ST_RUN);
    set_err  = err_q || illegal_stable;
  end

  // set terms are OR'd after the clear so a same-cycle set survives clr_sticky
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      raw_q        <= ST_ERROR_RESET;
      err_q        <= 1'b0;
      run_seen     <= 1'b0;
      link_dropped <= 1'b0;
      error_seen   <= 1'b0;
      trans_count  <= '0;
      state_change <= 1'b0;
    end else begin
      raw_q        <= link_state_t'(link_state);
      err_q        <= err_event;
      state_change <= commit;
      run_seen     <= set_run  || (run_seen     && !clr_sticky);
      link_dropped <= set_drop || (link_dropped && !clr_sticky);
      error_seen   <= set_err  || (error_seen   && !clr_sticky);
      if (clr_sticky) begin
        trans_count <= commit ? CNT_W'(1) : '0;
      end else if (commit && (trans_count != '1)) begin
        trans_count <= trans_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    fsm_info                    = '0;
    fsm_info[2:0]               = filt_state;
    fsm_info[INFO_RUN_SEEN]     = run_seen;
    fsm_info[INFO_LINK_DROPPED] = link_dropped;
    fsm_info[INFO_ERROR_SEEN]   = error_seen;
  end

`ifdef SPW_FSM_INFO_HIST_EN
  logic [11:0] hist_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist_q <= '0;
    end else if (commit) begin
      hist_q <= {hist_q[8:0], commit_state};
    end
  end

  assign hist_out = hist_q;
`endif

endmodule

// File: tb/tb_spw_fsm_info_capture.sv
// Self-checking bench for spw_fsm_info_capture: directed vector table, hand
// sequences and randomized stimulus against a run-length reference model.
module tb_spw_fsm_info_capture;

  localparam int unsigned SC   = 4;
  localparam int unsigned CW   = 8;
  localparam int          NVEC = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    link_state = 3'd0;
  logic          err_event = 1'b0;
  logic          clr_sticky = 1'b0;
  logic [5:0]    fsm_info;
  logic [CW-1:0] trans_count;
  logic          state_change;
`ifdef SPW_FSM_INFO_HIST_EN
  logic [11:0]   hist_out;
`endif

  spw_fsm_info_capture #(
    .STABLE_CYCLES (SC),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .link_state   (link_state),
    .err_event    (err_event),
    .clr_sticky   (clr_sticky),
    .fsm_info     (fsm_info),
    .trans_count  (trans_count),
`ifdef SPW_FSM_INFO_HIST_EN
    .hist_out     (hist_out),
`endif
    .state_change (state_change)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int sc_pulses = 0;

  // reference model: length of the current run of identical registered samples
  int          m_run = 0;
  logic [2:0]  m_prev = 3'd0;
  logic [2:0]  m_rq = 3'd0;
  logic        m_eq = 1'b0;
  logic [2:0]  m_filt = 3'd0;
  logic        m_run_seen = 1'b0, m_drop = 1'b0, m_err = 1'b0, m_sc = 1'b0;
  int          m_cnt = 0;
  logic [11:0] m_hist = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [2:0] s;
    logic e, reach, cm;
    if (!reset_n) begin
      m_run = 0; m_prev = 3'd0; m_rq = 3'd0; m_eq = 1'b0; m_filt = 3'd0;
      m_run_seen = 1'b0; m_drop = 1'b0; m_err = 1'b0; m_sc = 1'b0;
      m_cnt = 0; m_hist = '0;
    end else begin
      s = m_rq;
      e = m_eq;
      if (s == m_prev) begin
        if (m_run < 100000) m_run++;
      end else begin
        m_prev = s;
        m_run  = 1;
      end
      reach = (m_run == SC);
      cm    = reach && (s <= 3'd5) && (s != m_filt);
      m_sc  = cm;
      m_run_seen = (cm && s == 3'd5) || (m_run_seen && !clr_sticky);
      m_drop     = (cm && m_filt == 3'd5) || (m_drop && !clr_sticky);
      m_err      = e || (reach && s > 3'd5) || (m_err && !clr_sticky);
      if (clr_sticky) m_cnt = cm ? 1 : 0;
      else if (cm && m_cnt < 255) m_cnt++;
      if (cm) begin
        m_hist = {m_hist[8:0], s};
        m_filt = s;
      end
      m_rq = link_state;
      m_eq = err_event;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (state_change === 1'b1) sc_pulses++;
    check("model_info", fsm_info, {m_err, m_drop, m_run_seen, m_filt});
    check("model_cnt", trans_count, m_cnt);
    check("model_sc", state_change, m_sc);
`ifdef SPW_FSM_INFO_HIST_EN
    check("model_hist", hist_out, m_hist);
`endif
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    link_state = 3'd0; err_event = 1'b0; clr_sticky = 1'b0;
    for (int i = 0; i < n; i++) tick();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0] ls;
    int         hold;
    logic       ev;
    logic       clr;
    logic [5:0] info;
    int         cnt;
    int         pulses;
  } vec_t;

  vec_t tbl [NVEC];

  initial begin
    tbl[0]  = '{3'd0, 10, 1'b0, 1'b0, 6'h00, 0, 0};
    tbl[1]  = '{3'd1, 10, 1'b0, 1'b0, 6'h01, 1, 1};
    tbl[2]  = '{3'd2, 10, 1'b0, 1'b0, 6'h02, 2, 1};
    tbl[3]  = '{3'd4,  3, 1'b0, 1'b0, 6'h02, 2, 0};
    tbl[4]  = '{3'd2, 10, 1'b0, 1'b0, 6'h02, 2, 0};
    tbl[5]  = '{3'd3, 10, 1'b0, 1'b0, 6'h03, 3, 1};
    tbl[6]  = '{3'd4, 10, 1'b0, 1'b0, 6'h04, 4, 1};
    tbl[7]  = '{3'd5, 10, 1'b0, 1'b0, 6'h0D, 5, 1};
    tbl[8]  = '{3'd0, 10, 1'b0, 1'b0, 6'h18, 6, 1};
    tbl[9]  = '{3'd7,  6, 1'b0, 1'b0, 6'h38, 6, 0};
    tbl[10] = '{3'd0, 10, 1'b0, 1'b1, 6'h00, 0, 0};
    tbl[11] = '{3'd0,  3, 1'b1, 1'b0, 6'h20, 0, 0};

    // reset with active inputs, then exact commit latency after release
    reset_n = 1'b0; link_state = 3'd5; err_event = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rst_info", fsm_info, 6'h00);
    check("rst_cnt", trans_count, 0);
    check("rst_sc", state_change, 1'b0);
    reset_n = 1'b1; err_event = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rst_lat_early", fsm_info[2:0], 3'd0);
    tick();
    check("rst_lat_edge5", fsm_info[2:0], 3'd5);

    do_reset(3);
    for (int i = 0; i < NVEC; i++) begin
      link_state = tbl[i].ls;
      err_event  = tbl[i].ev;
      clr_sticky = tbl[i].clr;
      sc_pulses  = 0;
      for (int c = 0; c < tbl[i].hold; c++) begin
        tick();
        err_event  = 1'b0;
        clr_sticky = 1'b0;
      end
      check($sformatf("vec%0d_info", i), fsm_info, tbl[i].info);
      check($sformatf("vec%0d_cnt", i), trans_count, tbl[i].cnt);
      check($sformatf("vec%0d_pulses", i), sc_pulses, tbl[i].pulses);
    end

    // clear racing an error set, then a plain clear
    link_state = 3'd5;
    for (int i = 0; i < 10; i++) tick();
    check("race_pre_info", fsm_info, 6'h2D);
    err_event = 1'b1;
    tick();
    err_event = 1'b0; clr_sticky = 1'b1;
    tick();
    check("race_err_kept", fsm_info[5], 1'b1);
    tick();
    clr_sticky = 1'b0;
    check("clr_info", fsm_info, 6'h05);
    check("clr_cnt", trans_count, 0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) link_state = 3'($urandom_range(0, 7));
      err_event  = ($urandom_range(0, 19) == 0);
      clr_sticky = ($urandom_range(0, 24) == 0);
      reset_n    = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1'b1; err_event = 1'b0; clr_sticky = 1'b0;

    // counter saturation over 300 commits
    do_reset(2);
    for (int i = 0; i < 300; i++) begin
      link_state = (i % 2 == 0) ? 3'd1 : 3'd2;
      for (int c = 0; c < SC; c++) tick();
    end
    for (int c = 0; c < SC; c++) tick();
    check("sat_cnt", trans_count, 255);

`ifdef SPW_FSM_INFO_HIST_EN
    do_reset(2);
    link_state = 3'd1;
    for (int c = 0; c < 6; c++) tick();
    link_state = 3'd2;
    for (int c = 0; c < 6; c++) tick();
    link_state = 3'd5;
    for (int c = 0; c < 6; c++) tick();
    check("hist_seq", hist_out, 12'b000_001_010_101);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
